time_keeper: RTL
================

TIME_KEEPER -- requirements
Module: time_keeper

Interface
REQ-001 Parameter TICK_DIV, default 100_000_000, clk cycles per one-second tick.
REQ-002 clk  in  1  system clock, single clock domain.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 set_en  in  1  level; 1 = setting mode, counting paused.
REQ-005 alarm_sel  in  1  level; with set_en=1, selects alarm (1) or current time (0) for setting.
REQ-006 btn_hour  in  1  single-cycle pulse, already debounced; increment hours.
REQ-007 btn_min  in  1  single-cycle pulse, already debounced; increment minutes.
REQ-008 alarm_en  in  1  level; arms the alarm.
REQ-009 disp_time  out  20  packed BCD time feeding the display controller.
REQ-010 cur_time  out  20  current time, packed BCD.
REQ-011 alarm_time  out  20  alarm time, packed BCD; seconds field always 00.
REQ-012 alarm_ring  out  1  alarm active.
REQ-013 tick_1hz  out  1  single-cycle pulse per elapsed second in RUN.

Function
REQ-014 The time format SHALL be: [19:18] hour tens 0-2, [17:14] hour units, [13:11] minute tens 0-5, [10:7] minute units, [6:4] second tens 0-5, [3:0] second units.
REQ-015 The FSM SHALL have states RUN, SET_TIME, SET_ALARM; next state = RUN if set_en=0, SET_TIME if set_en=1 and alarm_sel=0, SET_ALARM if set_en=1 and alarm_sel=1; evaluated every cycle.
REQ-016 In RUN, the divider SHALL count 0..TICK_DIV-1; on wrap, cur_time SHALL advance one second on that edge and tick_1hz SHALL be 1 for the same cycle as the new cur_time value.
REQ-017 Advance SHALL ripple BCD: sec 59->00 carries to min, min 59->00 carries to hour, 23:59:59 -> 00:00:00.
REQ-018 In SET_TIME/SET_ALARM, the divider SHALL be held at 0 and tick_1hz SHALL stay 0.
REQ-019 In SET_TIME, btn_hour SHALL increment hours (23->00), btn_min SHALL increment minutes (59->00, no carry to hours) and clear seconds to 00; both pulses in one cycle SHALL both apply.
REQ-020 In SET_ALARM, buttons SHALL act identically on alarm_time; cur_time SHALL be unaffected.
REQ-021 In RUN, buttons SHALL NOT modify any time register.
REQ-022 disp_time SHALL equal alarm_time in SET_ALARM, else cur_time (combinational mux on registered state).
REQ-023 alarm_ring SHALL set on the cycle after cur_time becomes {alarm hh:mm, 00} in RUN with alarm_en=1.
REQ-024 alarm_ring SHALL clear on the cycle after any of: btn_hour or btn_min pulse, alarm_en=0, leaving RUN, or 60 ticks since set (6-bit ring counter); clear has priority over set.
REQ-025 A tick coinciding with a button pulse in RUN SHALL still advance cur_time.

Reset
REQ-026 On reset assertion (asynchronous): state=RUN, divider=0, cur_time=20'h00000, alarm_time=20'h18000 (06:00:00), alarm_ring=0, tick_1hz=0, ring counter=0; disp_time therefore 20'h00000.
REQ-027 Reset mid-ring or mid-setting SHALL abandon the operation with no residual state.

Structure
REQ-028 Package time_pkg SHALL hold the state enum, field bit-position constants, reset time constants, and BCD increment functions.
REQ-029 One sub-module, tick_gen (divider with synchronous hold and single-cycle tick), SHALL be used; all else in time_keeper.

Verification (TICK_DIV=4)
REQ-030 Reset -> cur_time=0x00000, alarm_time=0x18000, disp_time=0x00000, alarm_ring=0, tick_1hz=0.
REQ-031 SET_TIME, 23 btn_hour + 59 btn_min, set_en=0 -> cur_time 0x8EC80; after 59 ticks 0x8ECD9; next tick 0x00000.
REQ-032 SET_TIME from 00:00:00, 60 btn_min pulses -> minutes 00, hours 00; simultaneous btn_hour+btn_min -> 01:01:00 (0x04080).
REQ-033 SET_ALARM, 18 btn_hour + 1 btn_min -> alarm_time 0x00080, disp_time 0x00080, cur_time unchanged; alarm_en=1, RUN from 00:00:00 -> after 60 ticks cur_time 0x00080, alarm_ring=1 next cycle; btn_min pulse -> alarm_ring=0 next cycle, cur_time unchanged.
REQ-034 Same alarm, no button -> alarm_ring stays 1 for 60 ticks, then 0 at cur_time 0x00100.
REQ-035 Assert reset mid-ring and mid-SET_ALARM -> all outputs immediately at REQ-026 values, without a clk edge.

Source files
------------

// File: rtl/time_pkg.sv
// Shared types, field layout and BCD helpers for the time keeper.
// Time word: hh tens[19:18] hh units[17:14] mm tens[13:11] mm units[10:7] ss tens[6:4] ss units[3:0].
package time_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        SET_TIME  = 2'd1,
        SET_ALARM = 2'd2
    } state_t;

    localparam int H10_LSB = 18;
    localparam int H1_LSB  = 14;
    localparam int M10_LSB = 11;
    localparam int M1_LSB  = 7;
    localparam int S10_LSB = 4;
    localparam int S1_LSB  = 0;

    localparam logic [19:0] CUR_RESET   = 20'h00000;
    localparam logic [19:0] ALARM_RESET = 20'h18000;

    function automatic logic min_last(input logic [19:0] t);
        return (t[M10_LSB +: 3] == 3'd5) && (t[M1_LSB +: 4] == 4'd9);
    endfunction

    function automatic logic sec_last(input logic [19:0] t);
        return (t[S10_LSB +: 3] == 3'd5) && (t[S1_LSB +: 4] == 4'd9);
    endfunction

    // 23 -> 00, otherwise +1 in BCD
    function automatic logic [19:0] inc_hour(input logic [19:0] t);
        logic [19:0] r;
        r = t;
        if (t[H10_LSB +: 2] == 2'd2 && t[H1_LSB +: 4] == 4'd3) begin
            r[H10_LSB +: 2] = 2'd0;
            r[H1_LSB +: 4]  = 4'd0;
        end else if (t[H1_LSB +: 4] == 4'd9) begin
            r[H10_LSB +: 2] = t[H10_LSB +: 2] + 2'd1;
            r[H1_LSB +: 4]  = 4'd0;
        end else begin
            r[H1_LSB +: 4]  = t[H1_LSB +: 4] + 4'd1;
        end
        return r;
    endfunction

    // 59 -> 00 with no carry; the caller decides whether hours follow
    function automatic logic [19:0] inc_min(input logic [19:0] t);
        logic [19:0] r;
        r = t;
        if (min_last(t)) begin
            r[M10_LSB +: 3] = 3'd0;
            r[M1_LSB +: 4]  = 4'd0;
        end else if (t[M1_LSB +: 4] == 4'd9) begin
            r[M10_LSB +: 3] = t[M10_LSB +: 3] + 3'd1;
            r[M1_LSB +: 4]  = 4'd0;
        end else begin
            r[M1_LSB +: 4]  = t[M1_LSB +: 4] + 4'd1;
        end
        return r;
    endfunction

    function automatic logic [19:0] advance_sec(input logic [19:0] t);
        logic [19:0] r;
        r = t;
        if (!sec_last(t)) begin
            if (t[S1_LSB +: 4] == 4'd9) begin
                r[S10_LSB +: 3] = t[S10_LSB +: 3] + 3'd1;
                r[S1_LSB +: 4]  = 4'd0;
            end else begin
                r[S1_LSB +: 4]  = t[S1_LSB +: 4] + 4'd1;
            end
        end else begin
            r[S10_LSB +: 3] = 3'd0;
            r[S1_LSB +: 4]  = 4'd0;
            r = min_last(t) ? inc_hour(inc_min(r)) : inc_min(r);
        end
        return r;
    endfunction

    // Setting-mode edit: both buttons may land in the same cycle
    function automatic logic [19:0] apply_btns(input logic [19:0] t,
                                               input logic hour, input logic min);
        logic [19:0] r;
        r = t;
        if (hour)
            r = inc_hour(r);
        if (min) begin
            r = inc_min(r);
            r[S10_LSB +: 3] = 3'd0;
            r[S1_LSB +: 4]  = 4'd0;
        end
        return r;
    endfunction

endpackage

// File: rtl/time_keeper_tick_gen.sv
// One-second divider: free-runs 0..TICK_DIV-1, held at zero while hold is high.
// wrap is the combinational last-count strobe; tick is its registered copy.
module tick_gen #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic hold,
    output logic wrap,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt;

    assign wrap = !hold && (cnt == CW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (hold) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= wrap ? '0 : cnt + 1'b1;
            tick <= wrap;
        end
    end

endmodule

// File: rtl/time_keeper.sv
// 24h BCD clock with settable time/alarm and a one-minute alarm ring.
module time_keeper
    import time_pkg::*;
#(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        set_en,
    input  logic        alarm_sel,
    input  logic        btn_hour,
    input  logic        btn_min,
    input  logic        alarm_en,
    output logic [19:0] disp_time,
    output logic [19:0] cur_time,
    output logic [19:0] alarm_time,
    output logic        alarm_ring,
    output logic        tick_1hz
);

    state_t     state, state_nx;
    logic       wrap;
    logic [5:0] ring_cnt;
    logic       alarm_hit, ring_stop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= RUN;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = RUN;
        if (set_en)
            state_nx = alarm_sel ? SET_ALARM : SET_TIME;
    end

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (reset),
        .hold (state != RUN),
        .wrap (wrap),
        .tick (tick_1hz)
    );

    // Buttons are ignored in RUN; a wrap always advances the clock there.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_time   <= CUR_RESET;
            alarm_time <= ALARM_RESET;
        end else begin
            case (state)
                RUN:       if (wrap) cur_time <= advance_sec(cur_time);
                SET_TIME:  cur_time   <= apply_btns(cur_time, btn_hour, btn_min);
                SET_ALARM: alarm_time <= apply_btns(alarm_time, btn_hour, btn_min);
                default:   ;
            endcase
        end
    end

    // Match only on the cycle the new second appears, so a cleared ring
    // does not re-fire while cur_time still equals the alarm.
    assign alarm_hit = tick_1hz && (state == RUN) && alarm_en &&
                       (cur_time == {alarm_time[19:M1_LSB], 7'd0});

    assign ring_stop = btn_hour || btn_min || !alarm_en || (state_nx != RUN) ||
                       (alarm_ring && tick_1hz && ring_cnt == 6'd59);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alarm_ring <= 1'b0;
            ring_cnt   <= 6'd0;
        end else if (ring_stop) begin
            alarm_ring <= 1'b0;
            ring_cnt   <= 6'd0;
        end else if (alarm_hit) begin
            alarm_ring <= 1'b1;
            ring_cnt   <= 6'd0;
        end else if (alarm_ring && tick_1hz) begin
            ring_cnt   <= ring_cnt + 6'd1;
        end
    end

    assign disp_time = (state == SET_ALARM) ? alarm_time : cur_time;

endmodule
